// File: rtl/tlb_pkg.sv
// Shared types and helpers for the multi-port joint TLB.
//   tlb_entry_t  : one stored TLB entry (mask, VPN2, ASID, G, even/odd page data)
//   tlb_result_t : one translation result (pa, miss, valid, dirty, multihit, cattr)
//   entry_match  : VPN2/ASID match of one entry against a VA
//   page_odd     : even/odd page select bit for a given PageMask
package tlb_pkg;

    localparam logic [2:0]  CACHE_UNCACHED = 3'd3;
    localparam logic [31:0] PROBE_MISS     = 32'h8000_0000;

    typedef struct packed {
        logic [11:0] mask;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] pa;
        logic        miss;
        logic        valid;
        logic        dirty;
        logic        multihit;
        logic [2:0]  cattr;
    } tlb_result_t;

    localparam tlb_entry_t ENTRY_RST = '{
        mask: 12'h0, vpn2: 19'h0, asid: 8'h0, g: 1'b0,
        pfn0: 20'h0, c0: CACHE_UNCACHED, d0: 1'b0, v0: 1'b0,
        pfn1: 20'h0, c1: CACHE_UNCACHED, d1: 1'b0, v1: 1'b0
    };

    localparam tlb_result_t RESULT_RST = '{
        pa: 32'h0, miss: 1'b0, valid: 1'b0, dirty: 1'b0, multihit: 1'b0,
        cattr: CACHE_UNCACHED
    };

    localparam tlb_result_t RESULT_MISS = '{
        pa: 32'h0, miss: 1'b1, valid: 1'b0, dirty: 1'b0, multihit: 1'b0,
        cattr: CACHE_UNCACHED
    };

    // Mask bits cover VA[24:13]; masked bits are ignored in the VPN2 compare.
    function automatic logic entry_match(input tlb_entry_t e, input logic [31:0] va,
                                         input logic [7:0] asid);
        logic [18:0] vmask;
        vmask = {7'b0, e.mask};
        return ((va[31:13] & ~vmask) == (e.vpn2 & ~vmask)) && (e.g || (e.asid == asid));
    endfunction

    // Mask is contiguous from bit 0, so the page-select bit sits just above
    // the page offset: VA[12 + popcount(mask)].
    function automatic logic page_odd(input logic [31:0] va, input logic [11:0] mask);
        logic [4:0] k;
        k = 5'd0;
        for (int i = 0; i < 12; i++) begin
            k = k + 5'(mask[i]);
        end
        return va[5'd12 + k];
    endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Combinational fully associative lookup of one VA against all entries.
//   va_i      : virtual address to translate
//   asid_i    : current ASID
//   entries_i : the whole entry array
//   result_o  : translation result (lowest matching index wins)
//   hit_idx_o : index of the winning entry (0 on miss)
module tlb_lookup
    import tlb_pkg::*;
#(
    parameter int TLB_NUM  = 32,
    parameter int IDX_BITS = $clog2(TLB_NUM)
) (
    input  logic [31:0]         va_i,
    input  logic [7:0]          asid_i,
    input  tlb_entry_t          entries_i [TLB_NUM],
    output tlb_result_t         result_o,
    output logic [IDX_BITS-1:0] hit_idx_o
);

    logic        hit;
    logic        multi;
    logic        odd;
    tlb_entry_t  sel;
    logic [19:0] pfn;
    logic [31:0] page_mask;

    always_comb begin
        // NOTE: every variable gets a default before any conditional code so
        // no path leaves one unassigned, which would infer a latch.
        hit       = 1'b0;
        multi     = 1'b0;
        sel       = ENTRY_RST;
        hit_idx_o = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            if (entry_match(entries_i[i], va_i, asid_i)) begin
                if (!hit) begin
                    hit       = 1'b1;
                    sel       = entries_i[i];
                    hit_idx_o = IDX_BITS'(i);
                end else begin
                    multi = 1'b1;
                end
            end
        end

        page_mask = {8'h00, sel.mask, 12'hfff};
        odd       = page_odd(va_i, sel.mask);
        pfn       = odd ? sel.pfn1 : sel.pfn0;

        result_o = RESULT_MISS;
        if (hit) begin
            result_o.pa       = ({pfn, 12'h000} & ~page_mask) | (va_i & page_mask);
            result_o.miss     = 1'b0;
            result_o.valid    = odd ? sel.v1 : sel.v0;
            result_o.dirty    = odd ? sel.d1 : sel.d0;
            result_o.cattr    = odd ? sel.c1 : sel.c0;
            result_o.multihit = multi;
        end
    end

endmodule

// File: rtl/tlb_mp.sv
// Multi-port MIPS-style joint TLB.
//   tlbwi/tlbwr + index_i/mask_i/entryhi_i/entrylo*_i : entry writes
//   wired_we/wired_i, random_o                        : Wired/Random pair
//   tlbr -> rd_valid_o, mask_o, entryhi_o, entrylo*_o : registered read
//   tlbp -> probe_valid_o, probe_index_o              : registered probe
//   va_i/va_bak_i/va_sel_i/port_en_i/flush_i          : per-port lookup inputs
//   pa_o/miss_o/valid_o/dirty_o/multihit_o/cattr_o    : per-port registered results
module tlb_mp
    import tlb_pkg::*;
#(
    parameter int TLB_NUM   = 32,
    parameter int IDX_BITS  = $clog2(TLB_NUM),
    parameter int NUM_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tlbwi,
    input  logic                       tlbwr,
    input  logic [IDX_BITS-1:0]        index_i,
    input  logic [11:0]                mask_i,
    input  logic [31:0]                entryhi_i,
    input  logic [31:0]                entrylo0_i,
    input  logic [31:0]                entrylo1_i,
    input  logic                       wired_we,
    input  logic [IDX_BITS-1:0]        wired_i,
    output logic [IDX_BITS-1:0]        random_o,
    input  logic                       tlbr,
    output logic                       rd_valid_o,
    output logic [11:0]                mask_o,
    output logic [31:0]                entryhi_o,
    output logic [31:0]                entrylo0_o,
    output logic [31:0]                entrylo1_o,
    input  logic                       tlbp,
    output logic                       probe_valid_o,
    output logic [31:0]                probe_index_o,
    input  logic [NUM_PORTS-1:0][31:0] va_i,
    input  logic [NUM_PORTS-1:0][31:0] va_bak_i,
    input  logic [NUM_PORTS-1:0]       va_sel_i,
    input  logic [NUM_PORTS-1:0]       port_en_i,
    input  logic [NUM_PORTS-1:0]       flush_i,
    output logic [NUM_PORTS-1:0][31:0] pa_o,
    output logic [NUM_PORTS-1:0]       miss_o,
    output logic [NUM_PORTS-1:0]       valid_o,
    output logic [NUM_PORTS-1:0]       dirty_o,
    output logic [NUM_PORTS-1:0]       multihit_o,
    output logic [NUM_PORTS-1:0][2:0]  cattr_o
);

    localparam logic [IDX_BITS-1:0] RANDOM_TOP = IDX_BITS'(TLB_NUM - 1);

    tlb_entry_t          entries_q [TLB_NUM];
    tlb_entry_t          entries_d [TLB_NUM];
    tlb_entry_t          new_entry;
    logic [IDX_BITS-1:0] wr_idx;

    logic [IDX_BITS-1:0] wired_q, wired_d;
    logic [IDX_BITS-1:0] random_q, random_d;

    logic                rd_valid_q, rd_valid_d;
    logic [11:0]         mask_q, mask_d;
    logic [31:0]         entryhi_q, entryhi_d;
    logic [31:0]         entrylo0_q, entrylo0_d;
    logic [31:0]         entrylo1_q, entrylo1_d;

    logic                probe_valid_q, probe_valid_d;
    logic [31:0]         probe_index_q, probe_index_d;
    tlb_result_t         probe_res;
    logic [IDX_BITS-1:0] probe_idx;

    tlb_result_t         port_res [NUM_PORTS];
    tlb_result_t         res_q [NUM_PORTS];
    tlb_result_t         res_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][IDX_BITS-1:0] unused_port_idx;
    logic                unused_ok;

    // ---------------- lookups (read the pre-write contents) ----------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        tlb_lookup #(.TLB_NUM(TLB_NUM), .IDX_BITS(IDX_BITS)) u_lookup (
            .va_i      (va_sel_i[p] ? va_i[p] : va_bak_i[p]),
            .asid_i    (entryhi_i[7:0]),
            .entries_i (entries_q),
            .result_o  (port_res[p]),
            .hit_idx_o (unused_port_idx[p])
        );
    end

    tlb_lookup #(.TLB_NUM(TLB_NUM), .IDX_BITS(IDX_BITS)) u_probe (
        .va_i      (entryhi_i),
        .asid_i    (entryhi_i[7:0]),
        .entries_i (entries_q),
        .result_o  (probe_res),
        .hit_idx_o (probe_idx)
    );

    // Only the miss flag of the probe result and the low EntryLo fields matter.
    assign unused_ok = &{1'b0, probe_res, entrylo0_i[31:26], entrylo1_i[31:26], unused_port_idx};

    // ---------------- next-state logic ----------------
    always_comb begin
        new_entry.mask = mask_i;
        new_entry.vpn2 = entryhi_i[31:13] & ~{7'b0, mask_i};
        new_entry.asid = entryhi_i[7:0];
        new_entry.g    = entrylo0_i[0] & entrylo1_i[0];
        new_entry.pfn0 = entrylo0_i[25:6] & ~{8'b0, mask_i};
        new_entry.c0   = entrylo0_i[5:3];
        new_entry.d0   = entrylo0_i[2];
        new_entry.v0   = entrylo0_i[1];
        new_entry.pfn1 = entrylo1_i[25:6] & ~{8'b0, mask_i};
        new_entry.c1   = entrylo1_i[5:3];
        new_entry.d1   = entrylo1_i[2];
        new_entry.v1   = entrylo1_i[1];

        // TLBWI has priority; TLBWR uses the Random value of this cycle.
        wr_idx    = tlbwi ? index_i : random_q;
        entries_d = entries_q;
        if (tlbwi || tlbwr) begin
            entries_d[wr_idx] = new_entry;
        end

        wired_d = wired_we ? wired_i : wired_q;
        if (wired_we || (random_q <= wired_q)) begin
            random_d = RANDOM_TOP;
        end else begin
            random_d = random_q - IDX_BITS'(1);
        end

        rd_valid_d = tlbr;
        mask_d     = mask_q;
        entryhi_d  = entryhi_q;
        entrylo0_d = entrylo0_q;
        entrylo1_d = entrylo1_q;
        if (tlbr) begin
            mask_d     = entries_q[index_i].mask;
            entryhi_d  = {entries_q[index_i].vpn2, 5'b0, entries_q[index_i].asid};
            entrylo0_d = {6'b0, entries_q[index_i].pfn0, entries_q[index_i].c0,
                          entries_q[index_i].d0, entries_q[index_i].v0, entries_q[index_i].g};
            entrylo1_d = {6'b0, entries_q[index_i].pfn1, entries_q[index_i].c1,
                          entries_q[index_i].d1, entries_q[index_i].v1, entries_q[index_i].g};
        end

        probe_valid_d = tlbp;
        probe_index_d = probe_index_q;
        if (tlbp) begin
            probe_index_d = probe_res.miss ? PROBE_MISS : 32'(probe_idx);
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (flush_i[p]) begin
                res_d[p] = RESULT_RST;
            end else if (port_en_i[p]) begin
                res_d[p] = port_res[p];
            end else begin
                res_d[p] = res_q[p];
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entry array is reset like any other register because
            // software relies on C = 3 and V = 0 in never-written entries.
            for (int i = 0; i < TLB_NUM; i++) begin
                entries_q[i] <= ENTRY_RST;
            end
            wired_q       <= '0;
            random_q      <= RANDOM_TOP;
            rd_valid_q    <= 1'b0;
            mask_q        <= '0;
            entryhi_q     <= '0;
            entrylo0_q    <= '0;
            entrylo1_q    <= '0;
            probe_valid_q <= 1'b0;
            probe_index_q <= PROBE_MISS;
            for (int p = 0; p < NUM_PORTS; p++) begin
                res_q[p] <= RESULT_RST;
            end
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // values from before this edge, independent of statement order.
            entries_q     <= entries_d;
            wired_q       <= wired_d;
            random_q      <= random_d;
            rd_valid_q    <= rd_valid_d;
            mask_q        <= mask_d;
            entryhi_q     <= entryhi_d;
            entrylo0_q    <= entrylo0_d;
            entrylo1_q    <= entrylo1_d;
            probe_valid_q <= probe_valid_d;
            probe_index_q <= probe_index_d;
            res_q         <= res_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            pa_o[p]       = res_q[p].pa;
            miss_o[p]     = res_q[p].miss;
            valid_o[p]    = res_q[p].valid;
            dirty_o[p]    = res_q[p].dirty;
            multihit_o[p] = res_q[p].multihit;
            cattr_o[p]    = res_q[p].cattr;
        end
    end

    assign random_o      = random_q;
    assign rd_valid_o    = rd_valid_q;
    assign mask_o        = mask_q;
    assign entryhi_o     = entryhi_q;
    assign entrylo0_o    = entrylo0_q;
    assign entrylo1_o    = entrylo1_q;
    assign probe_valid_o = probe_valid_q;
    assign probe_index_o = probe_index_q;

endmodule

// File: tb/tb_tlb_mp.sv
// Directed self-checking bench for tlb_mp (32 entries, 2 ports).
module tb_tlb_mp;

    logic             clk = 1'b0;
    logic             rst;
    logic             tlbwi, tlbwr;
    logic [4:0]       index_i;
    logic [11:0]      mask_i;
    logic [31:0]      entryhi_i, entrylo0_i, entrylo1_i;
    logic             wired_we;
    logic [4:0]       wired_i;
    logic [4:0]       random_o;
    logic             tlbr, rd_valid_o;
    logic [11:0]      mask_o;
    logic [31:0]      entryhi_o, entrylo0_o, entrylo1_o;
    logic             tlbp, probe_valid_o;
    logic [31:0]      probe_index_o;
    logic [1:0][31:0] va_i, va_bak_i, pa_o;
    logic [1:0]       va_sel_i, port_en_i, flush_i;
    logic [1:0]       miss_o, valid_o, dirty_o, multihit_o;
    logic [1:0][2:0]  cattr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_mp #(.TLB_NUM(32), .NUM_PORTS(2)) dut (
        .clk(clk), .rst(rst), .tlbwi(tlbwi), .tlbwr(tlbwr), .index_i(index_i),
        .mask_i(mask_i), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
        .entrylo1_i(entrylo1_i), .wired_we(wired_we), .wired_i(wired_i),
        .random_o(random_o), .tlbr(tlbr), .rd_valid_o(rd_valid_o), .mask_o(mask_o),
        .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
        .tlbp(tlbp), .probe_valid_o(probe_valid_o), .probe_index_o(probe_index_o),
        .va_i(va_i), .va_bak_i(va_bak_i), .va_sel_i(va_sel_i), .port_en_i(port_en_i),
        .flush_i(flush_i), .pa_o(pa_o), .miss_o(miss_o), .valid_o(valid_o),
        .dirty_o(dirty_o), .multihit_o(multihit_o), .cattr_o(cattr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] make_lo(input logic [19:0] pfn, input logic [2:0] c,
                                            input logic d, input logic v, input logic g);
        return {6'b0, pfn, c, d, v, g};
    endfunction

    task automatic wr_tlb(input logic [4:0] idx, input logic [11:0] mask, input logic [31:0] hi,
                          input logic [31:0] lo0, input logic [31:0] lo1);
        index_i = idx; mask_i = mask; entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1;
        tlbwi = 1'b1;
        step();
        tlbwi = 1'b0;
    endtask

    task automatic rd_tlb(input logic [4:0] idx);
        index_i = idx;
        tlbr = 1'b1;
        step();
        tlbr = 1'b0;
        check("rd_valid", 32'(rd_valid_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_rand;
        rst = 1'b1; tlbwi = 0; tlbwr = 0; index_i = 0; mask_i = 0;
        entryhi_i = 0; entrylo0_i = 0; entrylo1_i = 0; wired_we = 0; wired_i = 0;
        tlbr = 0; tlbp = 0; va_i = '0; va_bak_i = '0; va_sel_i = 2'b11;
        port_en_i = 2'b11; flush_i = 2'b00;
        step(); step();

        // reset state (still in reset)
        check("rst_random", 32'(random_o), 32'd31);
        check("rst_pa0", pa_o[0], 32'h0);
        check("rst_miss0", 32'(miss_o[0]), 32'd0);
        check("rst_cattr0", 32'(cattr_o[0]), 32'd3);
        check("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check("rst_probe_valid", 32'(probe_valid_o), 32'd0);
        check("rst_probe_index", probe_index_o, 32'h8000_0000);
        rst = 1'b0;
        step();

        // TLBWI entry 5; lookup in the write cycle sees old contents
        va_i[0] = 32'h0080_1abc; va_bak_i[1] = 32'h0080_0abc; va_sel_i = 2'b01;
        wr_tlb(5'd5, 12'h0, 32'h0080_0001, make_lo(20'h12, 3'd2, 1, 1, 0),
               make_lo(20'h34, 3'd5, 0, 1, 0));
        check("same_cycle_miss0", 32'(miss_o[0]), 32'd1);
        step();
        check("hit_pa0", pa_o[0], 32'h0003_4abc);
        check("hit_valid0", 32'(valid_o[0]), 32'd1);
        check("hit_dirty0", 32'(dirty_o[0]), 32'd0);
        check("hit_miss0", 32'(miss_o[0]), 32'd0);
        check("hit_cattr0", 32'(cattr_o[0]), 32'd5);
        check("bak_pa1", pa_o[1], 32'h0001_2abc);
        check("bak_dirty1", 32'(dirty_o[1]), 32'd1);
        check("bak_cattr1", 32'(cattr_o[1]), 32'd2);

        // ASID mismatch with G = 0, then hit with G = 1
        entryhi_i = 32'h0080_0002;
        step();
        check("asid_miss0", 32'(miss_o[0]), 32'd1);
        check("asid_pa0", pa_o[0], 32'h0);
        check("asid_cattr0", 32'(cattr_o[0]), 32'd3);
        check("asid_valid0", 32'(valid_o[0]), 32'd0);
        wr_tlb(5'd5, 12'h0, 32'h0080_0001, make_lo(20'h12, 3'd2, 1, 1, 1),
               make_lo(20'h34, 3'd5, 0, 1, 1));
        entryhi_i = 32'h0080_0002;
        step();
        check("global_miss0", 32'(miss_o[0]), 32'd0);
        check("global_pa0", pa_o[0], 32'h0003_4abc);

        // multi-hit on entries 3 and 9; G of entry 9 is lo0.G & lo1.G = 0
        wr_tlb(5'd3, 12'h0, 32'h0100_0001, make_lo(20'h55, 3'd1, 0, 1, 0),
               make_lo(20'h56, 3'd1, 0, 1, 0));
        wr_tlb(5'd9, 12'h0, 32'h0100_0001, make_lo(20'h66, 3'd4, 1, 1, 1),
               make_lo(20'h67, 3'd4, 0, 1, 0));
        va_i[0] = 32'h0100_0123; entryhi_i = 32'h0100_0001; tlbp = 1'b1;
        step();
        tlbp = 1'b0;
        check("mh_pa0", pa_o[0], 32'h0005_5123);
        check("mh_multihit0", 32'(multihit_o[0]), 32'd1);
        check("mh_cattr0", 32'(cattr_o[0]), 32'd1);
        check("single_multihit1", 32'(multihit_o[1]), 32'd0);
        check("probe_valid", 32'(probe_valid_o), 32'd1);
        check("probe_index", probe_index_o, 32'd3);
        step();
        check("probe_valid_pulse", 32'(probe_valid_o), 32'd0);
        check("probe_index_hold", probe_index_o, 32'd3);
        rd_tlb(5'd9);
        check("rd9_hi", entryhi_o, 32'h0100_0001);
        check("rd9_lo0", entrylo0_o, make_lo(20'h66, 3'd4, 1, 1, 0));
        check("rd9_lo1", entrylo1_o, make_lo(20'h67, 3'd4, 0, 1, 0));
        step();
        check("rd_valid_pulse", 32'(rd_valid_o), 32'd0);
        entryhi_i = 32'h0100_0005;
        step();
        check("g_and_miss0", 32'(miss_o[0]), 32'd1);
        entryhi_i = 32'h0200_0001; tlbp = 1'b1;
        step();
        tlbp = 1'b0;
        check("probe_miss", probe_index_o, 32'h8000_0000);

        // 16K page: VA bit 14 selects the odd page; stored fields are masked
        wr_tlb(5'd12, 12'h003, 32'h0200_6001, make_lo(20'h101, 3'd2, 1, 1, 0),
               make_lo(20'h203, 3'd6, 0, 1, 0));
        va_i[0] = 32'h0200_2abc; va_bak_i[1] = 32'h0200_6abc;
        step();
        check("p16k_even_pa0", pa_o[0], 32'h0010_2abc);
        check("p16k_even_cattr0", 32'(cattr_o[0]), 32'd2);
        check("p16k_odd_pa1", pa_o[1], 32'h0020_2abc);
        check("p16k_odd_cattr1", 32'(cattr_o[1]), 32'd6);
        rd_tlb(5'd12);
        check("rd12_mask", 32'(mask_o), 32'h003);
        check("rd12_hi", entryhi_o, 32'h0200_0001);
        check("rd12_lo0", entrylo0_o, make_lo(20'h100, 3'd2, 1, 1, 0));

        // hold and flush (flush beats a disabled port)
        port_en_i = 2'b00; va_i[0] = 32'h0080_1abc;
        step();
        check("hold_pa0", pa_o[0], 32'h0010_2abc);
        flush_i = 2'b01;
        step();
        check("flush_pa0", pa_o[0], 32'h0);
        check("flush_miss0", 32'(miss_o[0]), 32'd0);
        check("flush_valid0", 32'(valid_o[0]), 32'd0);
        check("flush_cattr0", 32'(cattr_o[0]), 32'd3);
        check("flush_hold_pa1", pa_o[1], 32'h0020_2abc);
        flush_i = 2'b00; port_en_i = 2'b11;

        // Random/Wired; TLBWR at 17, TLBWI+TLBWR collision at 10
        wired_i = 5'd4; wired_we = 1'b1;
        step();
        wired_we = 1'b0;
        exp_rand = 31;
        for (int n = 0; n < 30; n++) begin
            check("random", 32'(random_o), 32'(exp_rand));
            mask_i = 12'h0; entrylo0_i = make_lo(20'h777, 3'd2, 0, 1, 0); entrylo1_i = 32'h0;
            if (exp_rand == 17) begin
                entryhi_i = 32'h0300_0001; tlbwr = 1'b1;
            end else if (exp_rand == 10) begin
                entryhi_i = 32'h0400_0001; index_i = 5'd20; tlbwr = 1'b1; tlbwi = 1'b1;
            end
            step();
            tlbwr = 1'b0; tlbwi = 1'b0;
            exp_rand = (exp_rand <= 4) ? 31 : exp_rand - 1;
        end
        rd_tlb(5'd17);
        check("tlbwr_hi17", entryhi_o, 32'h0300_0001);
        rd_tlb(5'd20);
        check("tlbwi_wins_hi20", entryhi_o, 32'h0400_0001);
        rd_tlb(5'd10);
        check("untouched_hi10", entryhi_o, 32'h0);
        check("untouched_lo10", entrylo0_o, 32'h0000_0018);

        // asynchronous reset mid-operation
        va_i[0] = 32'h0080_1abc; entryhi_i = 32'h0080_0001;
        step();
        check("pre_rst_pa0", pa_o[0], 32'h0003_4abc);
        #3 rst = 1'b1;
        #1;
        check("async_rst_pa0", pa_o[0], 32'h0);
        check("async_rst_random", 32'(random_o), 32'd31);
        check("async_rst_hi", entryhi_o, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_miss0", 32'(miss_o[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_mp.md
# tlb_mp

Fully associative MIPS-style joint TLB with a parametrised number of registered translation ports (fetch, load/store, extra ports as needed), priority resolution of multiple matches with a multi-hit flag, and a hardware Random/Wired pair for TLBWR. It sits between the CP0 register file and the fetch and memory pipeline stages. Each port returns a physical address and exception flags one cycle after it presents a virtual address.

## Interface
- `TLB_NUM`, default 32: number of entries.
- `IDX_BITS`, default `$clog2(TLB_NUM)`: index width.
- `NUM_PORTS`, default 2: translation ports.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous and active-high.
- `tlbwi` input 1: write entry `index_i` (TLBWI).
- `tlbwr` input 1: write entry `random_o` (TLBWR).
- `index_i` input IDX_BITS: CP0 Index, used by TLBWI and TLBR.
- `mask_i` input 12: PageMask[24:13].
- `entryhi_i` input 32: VPN2 in [31:13], ASID in [7:0]. Also supplies the ASID for all lookups.
- `entrylo0_i`, `entrylo1_i` input 32 each: PFN in [25:6], C in [5:3], D in [2], V in [1], G in [0].
- `wired_we` input 1: CP0 Wired write strobe.
- `wired_i` input IDX_BITS: new Wired value.
- `random_o` output IDX_BITS: current Random register.
- `tlbr` input 1: read request.
- `rd_valid_o` output 1: read data valid.
- `mask_o` output 12, `entryhi_o` output 32, `entrylo0_o` output 32, `entrylo1_o` output 32: registered TLBR data.
- `tlbp` input 1: probe request.
- `probe_valid_o` output 1: probe result valid.
- `probe_index_o` output 32: bit 31 set means miss; otherwise the index is in [IDX_BITS-1:0].
- `va_i` input NUM_PORTS×32: primary virtual address per port.
- `va_bak_i` input NUM_PORTS×32: alternate virtual address per port.
- `va_sel_i` input NUM_PORTS: 1 selects `va_i`, 0 selects `va_bak_i`.
- `port_en_i` input NUM_PORTS: 0 holds that port's output registers.
- `flush_i` input NUM_PORTS: forces that port's outputs to their reset values.
- `pa_o` output NUM_PORTS×32: physical address.
- `miss_o`, `valid_o`, `dirty_o`, `multihit_o` output NUM_PORTS each: translation flags.
- `cattr_o` output NUM_PORTS×3: cache attribute.

## Operation
- **Entry state.** Each entry holds mask, VPN2, ASID, G, and for the even and odd pages PFN, C, D and V.
- **Entry write.**
  - VPN2 and both PFNs are stored ANDed with `~mask`.
  - G is stored as `lo0.G & lo1.G`.
- **Write arbitration.** If `tlbwi` and `tlbwr` are both asserted, `tlbwi` wins.
- **Match condition.** An entry matches a VA when both hold:
  - `VA[31:13] & ~mask == VPN2 & ~mask`;
  - G is set, or the entry ASID equals `entryhi_i[7:0]`.
- **Even/odd page select.** The select bit is `VA[12+k]`, where k is the number of set bits in mask (mask is contiguous from bit 0). A select value of 1 chooses the odd page.
- **Multiple matches.** The lowest matching index wins. `multihit_o` is set when more than one entry matches.
- **Address formation.** `pa = (PFN<<12 & ~({mask,12'hfff})) | (VA & {mask,12'hfff})`.
- **Translation flags.**
  - `miss_o` is set when no entry matches.
  - `valid_o` and `dirty_o` come from the V and D bits of the selected page.
  - `cattr_o` comes from the C field of the selected page.
  - On a miss: `pa_o` = 0, `valid_o` = 0, `dirty_o` = 0, `cattr_o` = 3.
- **Probe.** The probe compares against `entryhi_i`, with the same lowest-index priority.
- **Random register.**
  - Updates every cycle: if `random <= wired`, next is `TLB_NUM-1`; otherwise it decrements.
  - `wired_we` loads Wired and forces Random to `TLB_NUM-1` on the next cycle.
  - A TLBWR in the same cycle uses the old Random value.

## Timing
- **Reset values.**
  - All entries: V = 0, D = 0, G = 0, all other fields 0, C = 3.
  - Wired = 0; Random = `TLB_NUM-1`.
  - Per port: `pa_o` = 0, `miss_o` = 0, `valid_o` = 0, `dirty_o` = 0, `multihit_o` = 0, `cattr_o` = 3.
  - `rd_valid_o` = 0, `probe_valid_o` = 0, read data = 0, `probe_index_o` = 32'h8000_0000.
- **Lookup latency.** A VA sampled at edge t produces its result after edge t+1.
- **Port priority.** For each port: `flush_i` beats `port_en_i`, which beats normal update.
- **TLBR and TLBP.** Each strobe produces its result and a one-cycle valid pulse on the next edge. Outside the pulse, the result registers hold their last value.
- **Write visibility.**
  - A write at edge t is visible to lookups, probes and reads sampled from cycle t+1 onward.
  - A lookup in the same cycle as the write sees the old contents.
- **Reset mid-operation.** Asserting `rst` clears every register immediately. In-flight lookups produce no result.
- **Back-to-back operation.** Each port accepts a new VA every cycle, with no stall.

## Structure
- Package `tlb_pkg` holds:
  - the `tlb_entry_t` packed struct;
  - the `tlb_result_t` struct (pa, miss, valid, dirty, multihit, cattr);
  - `CACHE_UNCACHED = 3`;
  - the `PROBE_MISS = 32'h8000_0000` constant.
- Sub-module `tlb_lookup` is purely combinational: it takes a VA, the ASID and the entry array and returns `tlb_result_t`.
- `tlb_lookup` is instantiated NUM_PORTS+1 times: once per port, and once for the probe, which uses only the index output.

## Test plan
- **TLBWI then lookup.** Write entry 5 with VPN2 = 0x00400 (4K page), ASID = 1, lo0 PFN = 0x12 V = 1 D = 1, lo1 PFN = 0x34 V = 1 D = 0.
  - Next cycle, look up VA 0x0080_1abc with ASID 1. Required one cycle later: `pa_o` = 0x0003_4abc, `valid_o` = 1, `dirty_o` = 0, `miss_o` = 0.
- **ASID mismatch.** With G = 0, look up the same VA with ASID 2.
  - Required: `miss_o` = 1, `pa_o` = 0, `cattr_o` = 3.
  - Repeating with G = 1 gives a hit.
- **Multi-hit.** Entries 3 and 9 both match.
  - Required: `multihit_o` = 1, data taken from entry 3, and a TLBP returns 3.
- **Random and Wired.** Write Wired = 4, then idle.
  - Required sequence of `random_o`: 31, 30, …, 5, 4, 31.
  - A TLBWR issued while `random_o` = 17 writes entry 17.
- **Flush, hold and 16K page.**
  - `flush_i` forces port outputs to their reset values.
  - `port_en_i` = 0 holds the previous result.
  - With mask = 0x003, VA bit 14 selects the odd page.
